// File: rtl/fp32_pkg.sv
// Shared constants, operand classes and field helpers for the fp32 <-> int32 datapath.
package fp32_pkg;

  localparam int unsigned BIAS      = 127;
  localparam logic [31:0] INT32_MAX = 32'h7FFFFFFF;
  localparam logic [31:0] INT32_MIN = 32'h80000000;
  localparam logic [7:0]  EXP_INF   = 8'hFF;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN,
    CLS_OVF
  } fp_class_e;

  function automatic logic fp_sign(input logic [31:0] f);
    return f[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] f);
    return f[30:23];
  endfunction

  function automatic logic [22:0] fp_man(input logic [31:0] f);
    return f[22:0];
  endfunction

endpackage

// File: rtl/rshift_sticky24.sv
// Combinational 24-bit right shifter returning the guard bit and the sticky OR of the rest.
module rshift_sticky24 (
  input  logic [23:0] value,
  input  logic [4:0]  amount,
  output logic [23:0] shifted,
  output logic        guard,
  output logic        sticky
);

  logic [49:0] ext;

  // Two spare low bits let an amount of 25 push every significand bit past the guard slot.
  assign ext     = {value, 26'd0} >> amount;
  assign shifted = ext[49:26];
  assign guard   = ext[25];
  assign sticky  = |ext[24:0];

endmodule

// File: rtl/fp32_to_int_pipeline.sv
// Two-stage binary32 -> int32 converter, round-to-nearest-even, valid/ready with global stall.
module fp32_to_int_pipeline
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Inexact
);

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: classify and pick the shift.
  logic              s_in;
  logic [7:0]        e_in;
  logic [22:0]       m_in;
  logic signed [8:0] unb, rsh, lsh;
  fp_class_e         cls_d;
  logic              left_d;
  logic [4:0]        amt_d;

  assign s_in = fp_sign(fp_in);
  assign e_in = fp_exp(fp_in);
  assign m_in = fp_man(fp_in);
  assign unb  = $signed({1'b0, e_in}) - $signed(9'(BIAS));
  assign rsh  = 9'sd23 - unb;
  assign lsh  = unb - 9'sd23;

  always_comb begin
    cls_d  = CLS_NORM;
    left_d = 1'b0;
    amt_d  = 5'd0;
    if (e_in == EXP_INF) begin
      cls_d = (m_in != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (e_in == 8'd0) begin
      cls_d = CLS_ZERO;
    end else if (unb <= 9'sd23) begin
      amt_d = (rsh > 9'sd25) ? 5'd25 : rsh[4:0];
    end else if (unb <= 9'sd30 || (s_in && e_in == 8'd158 && m_in == 23'd0)) begin
      // -2^31 is representable, so it rides the left-shift path instead of saturating.
      left_d = 1'b1;
      amt_d  = lsh[4:0];
    end else begin
      cls_d = CLS_OVF;
    end
  end

  logic        s1_valid, s1_sign, s1_left;
  fp_class_e   s1_cls;
  logic [4:0]  s1_amt;
  logic [23:0] s1_sig;

  // Stage 2: shift, round, negate, saturate.
  logic [23:0] rs_val;
  logic        rs_guard, rs_sticky;

  rshift_sticky24 u_rshift (
    .value   (s1_sig),
    .amount  (s1_amt),
    .shifted (rs_val),
    .guard   (rs_guard),
    .sticky  (rs_sticky)
  );

  logic [31:0] int_val, res_d;
  logic        guard, sticky, round_up;
  logic [32:0] mag;
  logic        exc_d, ovf_d, unf_d, inx_d;

  always_comb begin
    int_val  = 32'd0;
    guard    = 1'b0;
    sticky   = 1'b0;
    round_up = 1'b0;
    mag      = 33'd0;
    res_d    = 32'd0;
    exc_d    = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    inx_d    = 1'b0;
    case (s1_cls)
      CLS_NAN: begin
        res_d = INT32_MAX;
        exc_d = 1'b1;
      end
      CLS_INF: begin
        res_d = s1_sign ? INT32_MIN : INT32_MAX;
        exc_d = 1'b1;
        ovf_d = 1'b1;
      end
      CLS_ZERO: begin
        // Sticky slot holds the denormal mantissa's nonzero-ness.
        unf_d = |s1_sig;
        inx_d = |s1_sig;
      end
      CLS_OVF: begin
        res_d = s1_sign ? INT32_MIN : INT32_MAX;
        ovf_d = 1'b1;
        inx_d = 1'b1;
      end
      default: begin
        if (s1_left) begin
          int_val = {8'd0, s1_sig} << s1_amt;
        end else begin
          int_val = {8'd0, rs_val};
          guard   = rs_guard;
          sticky  = rs_sticky;
        end
        round_up = guard & (sticky | int_val[0]);
        mag      = {1'b0, int_val} + 33'(round_up);
        inx_d    = guard | sticky;
        if (!s1_sign && mag > {1'b0, INT32_MAX}) begin
          res_d = INT32_MAX;
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else if (s1_sign && mag > {1'b0, INT32_MIN}) begin
          res_d = INT32_MIN;
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else begin
          res_d = s1_sign ? -mag[31:0] : mag[31:0];
          unf_d = (mag == 33'd0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_cls    <= CLS_ZERO;
      s1_left   <= 1'b0;
      s1_amt    <= 5'd0;
      s1_sig    <= 24'd0;
      out_valid <= 1'b0;
      result    <= 32'd0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Inexact   <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sign   <= s_in;
      s1_cls    <= cls_d;
      s1_left   <= left_d;
      s1_amt    <= amt_d;
      s1_sig    <= {e_in != 8'd0, m_in};
      out_valid <= s1_valid;
      result    <= res_d;
      Exception <= exc_d;
      Overflow  <= ovf_d;
      Underflow <= unf_d;
      Inexact   <= inx_d;
    end
  end

endmodule

// File: tb/tb_fp32_to_int_pipeline.sv
// Randomised bench for fp32_to_int_pipeline with an arithmetic reference model and scoreboard.
module tb_fp32_to_int_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fp_in = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        Exception, Overflow, Underflow, Inexact;

  fp32_to_int_pipeline dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .Inexact   (Inexact)
  );

  always #5 clk = ~clk;

  // {result, Exception, Overflow, Underflow, Inexact}
  logic [35:0] obs;
  assign obs = {result, Exception, Overflow, Underflow, Inexact};

  typedef struct {
    logic [35:0] exp;
    int          acc;
  } item_t;

  item_t       sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        held = 1'b0;
  logic [35:0] held_out = 36'd0;
  logic        chk_lat = 1'b0;
  logic        accepted = 1'b0;

  logic [31:0] dir_in [13] = '{
    32'h3FC00000, 32'h40200000, 32'hC0200000, 32'h3F000000, 32'h3F400000,
    32'h00000001, 32'h4EFFFFFF, 32'h4F000000, 32'hCF000000, 32'hCF000001,
    32'h7FC00000, 32'hFF800000, 32'h80000000
  };
  logic [35:0] dir_exp [13] = '{
    {32'h00000002, 4'b0001}, {32'h00000002, 4'b0001}, {32'hFFFFFFFE, 4'b0001},
    {32'h00000000, 4'b0011}, {32'h00000001, 4'b0001}, {32'h00000000, 4'b0011},
    {32'h7FFFFF80, 4'b0000}, {32'h7FFFFFFF, 4'b0101}, {32'h80000000, 4'b0000},
    {32'h80000000, 4'b0101}, {32'h7FFFFFFF, 4'b1000}, {32'h80000000, 4'b1100},
    {32'h00000000, 4'b0000}
  };

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value = sig * 2^k; round by comparing the dropped remainder against one half.
  function automatic logic [35:0] ref_model(input logic [31:0] f);
    logic   s;
    int     e, k;
    longint sig, iv, rem, half, r, sv;
    logic   big;
    s    = f[31];
    e    = int'(f[30:23]);
    sig  = longint'({1'b1, f[22:0]});
    iv   = 0;
    rem  = 0;
    half = 1;
    big  = 1'b0;
    if (e == 255)
      return (f[22:0] != 23'd0) ? {32'h7FFFFFFF, 4'b1000}
                                : {s ? 32'h80000000 : 32'h7FFFFFFF, 4'b1100};
    if (e == 0) return {32'd0, 2'b00, f[22:0] != 23'd0, f[22:0] != 23'd0};
    k = e - 150;
    if (k > 32) big = 1'b1;
    else if (k >= 0) iv = sig << k;
    else if (k < -40) begin
      iv   = 0;
      rem  = sig;
      half = 64'sd1 << 40;
    end else begin
      iv   = sig >> (-k);
      rem  = sig - (iv << (-k));
      half = 64'sd1 << (-k - 1);
    end
    r = iv;
    if (rem > half || (rem == half && iv[0])) r = iv + 1;
    sv = s ? -r : r;
    if (big || sv > 64'sd2147483647 || sv < -64'sd2147483648)
      return {s ? 32'h80000000 : 32'h7FFFFFFF, 4'b0101};
    return {sv[31:0], 2'b00, r == 0, rem != 0};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: r[30:23] = 8'($urandom_range(118, 162));
      2: begin
        r[30:23] = 8'($urandom_range(124, 140));
        r[15:0]  = 16'd0;
      end
      default: begin
        r[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        if ($urandom_range(0, 1) != 0) r[22:0] = 23'd0;
      end
    endcase
    return r;
  endfunction

  // One clock: drive at negedge, sample 1ns later, score what the next posedge will transfer.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [35:0] e,
                       input logic ordy);
    item_t it;
    @(negedge clk);
    in_valid  = v;
    fp_in     = d;
    out_ready = ordy;
    #1;
    accepted = 1'b0;
    if (held) begin
      check("stall_valid", 36'(out_valid), 36'd1);
      check("stall_hold", obs, held_out);
    end
    held = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 36'(out_valid), 36'd0);
        end else begin
          it = sb.pop_front();
          check("result", obs, it.exp);
          if (chk_lat) check("latency", 36'(cyc - it.acc), 36'd2);
        end
      end else begin
        check("stall_in_ready", 36'(in_ready), 36'd0);
        held     = 1'b1;
        held_out = obs;
      end
    end
    if (in_valid && in_ready) begin
      it.exp = e;
      it.acc = cyc;
      sb.push_back(it);
      accepted = 1'b1;
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() > 0; i++) cycle(1'b0, 32'd0, 36'd0, 1'b1);
    check("drain_empty", 36'(sb.size()), 36'd0);
  endtask

  initial begin
    logic [31:0] bp_data [8];
    logic [31:0] d;
    int          idx;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_valid", 36'(out_valid), 36'd0);
    check("reset_out", obs, 36'd0);
    check("reset_in_ready", 36'(in_ready), 36'd1);

    chk_lat = 1'b1;
    for (int i = 0; i < 13; i++) cycle(1'b1, dir_in[i], dir_exp[i], 1'b1);
    drain();

    for (int i = 0; i < 150; i++) begin
      d = rand_fp();
      cycle(1'($urandom_range(0, 3) != 0), d, ref_model(d), 1'b1);
    end
    drain();
    chk_lat = 1'b0;

    for (int i = 0; i < 8; i++) bp_data[i] = rand_fp();
    idx = 0;
    for (int t = 0; t < 200 && idx < 8; t++) begin
      cycle(1'b1, bp_data[idx], ref_model(bp_data[idx]), 1'($urandom_range(0, 1)));
      if (accepted) idx++;
    end
    check("bp_accepted", 36'(idx), 36'd8);
    drain();

    for (int i = 0; i < 300; i++) begin
      d = rand_fp();
      cycle(1'($urandom_range(0, 1)), d, ref_model(d), 1'($urandom_range(0, 2) != 0));
    end
    drain();

    cycle(1'b1, 32'h3FC00000, ref_model(32'h3FC00000), 1'b1);
    cycle(1'b1, 32'h40200000, ref_model(32'h40200000), 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", 36'(out_valid), 36'd0);
    check("midrst_out", obs, 36'd0);
    check("midrst_in_ready", 36'(in_ready), 36'd1);
    sb.delete();
    held = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'd0, 36'd0, 1'b1);
      check("no_stale", 36'(out_valid), 36'd0);
    end
    d = 32'hC0200000;
    cycle(1'b1, d, ref_model(d), 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp32_to_int_pipeline.md
# fp32_to_int_pipeline

Two-stage pipelined converter from IEEE-754 binary32 to signed 32-bit two's-complement integer, with round-to-nearest-even. It is the inverse of the integer-to-fp32 pipeline in the FP datapath and carries the same flag set (Exception / Overflow / Underflow), plus Inexact. It uses a valid/ready handshake with a global stall, so it can sit between buffered producers and consumers.

## Interface
- No parameters. Widths are fixed at 32 bits.
- `clk`: input, 1 bit. Single clock.
- `rst`: input, 1 bit. Reset, synchronous and active-low.
- `in_valid`: input, 1 bit. `fp_in` holds a valid operand.
- `in_ready`: output, 1 bit. The pipeline can accept an operand this cycle.
- `fp_in`: input, 32 bits. Binary32 operand.
- `out_valid`: output, 1 bit. `result` and the flags are valid.
- `out_ready`: input, 1 bit. The consumer accepts the output this cycle.
- `result`: output, 32 bits. Signed integer result.
- `Exception`: output, 1 bit. Input is NaN or ±Inf.
- `Overflow`: output, 1 bit. Input magnitude is outside the int32 range; the result saturates.
- `Underflow`: output, 1 bit. Finite nonzero input rounded to 0.
- `Inexact`: output, 1 bit. Result differs from the input value.

## Operation
- Fields: s = `fp_in[31]`, e = `fp_in[30:23]`, m = `fp_in[22:0]`. Unbiased exponent E = e − 127, computed as a signed 9-bit value. Significand sig = {1, m}, 24 bits.
- e = 255 with m ≠ 0 (NaN): result 0x7FFFFFFF, Exception = 1, all other flags 0.
- e = 255 with m = 0 (±Inf): result 0x7FFFFFFF for +Inf and 0x80000000 for −Inf. Exception = 1, Overflow = 1.
- e = 0 (zero or denormal): result 0. Underflow = Inexact = 1 if m ≠ 0. The sign is ignored.
- 0 ≤ 23 − E, i.e. E ≤ 23: right shift sig by r = 23 − E, with r clamped to 25.
  - Integer part is the shifted value.
  - Guard = first discarded bit.
  - Sticky = OR of all remaining discarded bits.
- 24 ≤ E ≤ 30: left shift sig by E − 23. The result is exact: guard = sticky = 0.
- E ≥ 31: Overflow. The single exception is s = 1, e = 158, m = 0, which gives exactly 0x80000000 with no flag.
- Rounding: round_up = guard & (sticky | int_lsb). mag = int + round_up, 33 bits wide.
- Sign application:
  - If s = 0 and mag > 0x7FFFFFFF: saturate to 0x7FFFFFFF, Overflow = 1.
  - If s = 1 and mag > 0x80000000: saturate to 0x80000000, Overflow = 1.
  - Otherwise result = s ? −mag : mag. −0 yields 0.
- Flag rules for finite in-range inputs:
  - Inexact = guard | sticky.
  - Underflow = (input ≠ 0) & (mag = 0).
- Flag rules for saturated finite inputs: Overflow = 1, Inexact = 1, Exception = 0.

## Timing
- Stage 1 register: s, class (zero / NaN / Inf / overflow / normal), clamped shift amount, shift direction, sig, and s1_valid.
- Stage 2 register: shift, round, negate, saturate. It holds `result`, the flags and `out_valid`.
- Global advance: en = !out_valid | out_ready.
  - in_ready = en, combinationally.
  - Both stages load only when en = 1.
  - A bubble (s1_valid = 0) propagates as out_valid = 0.
- Latency: 2 cycles from an accepted input to out_valid when no stall occurs. Throughput is 1 per cycle.
- While out_valid = 1 and out_ready = 0: `result`, the flags and both stages hold stable. in_ready = 0 and no input is lost.
- Reset (rst = 0 at a clock edge):
  - All valids go to 0; `result` and all flags go to 0.
  - Operands in flight are discarded.
  - in_ready = 1 in the first cycle after reset.
- Simultaneous output accept and new input: both occur in the same cycle with no bubble.

## Structure
- Package `fp32_pkg` holds:
  - BIAS = 127.
  - INT32_MAX = 32'h7FFFFFFF and INT32_MIN = 32'h80000000.
  - EXP_INF = 8'hFF.
  - The class enum {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN, CLS_OVF}.
  - Field-extract functions, shared with the int-to-fp32 pipeline.
- Sub-module `rshift_sticky24` (combinational):
  - Inputs: 24-bit value, 5-bit amount (0–25).
  - Outputs: 24-bit shifted value, guard bit, sticky bit.
- Stage 2 instantiates `rshift_sticky24`. The left-shift path and the rounding logic stay inline.

## Test plan
- Rounding, out_ready held at 1:
  - 0x3FC00000 (1.5) → 0x00000002, Inexact.
  - 0x40200000 (2.5) → 0x00000002, Inexact.
  - 0xC0200000 (−2.5) → 0xFFFFFFFE, Inexact.
  - Each output appears exactly 2 cycles after acceptance.
- Small values:
  - 0x3F000000 (0.5) → 0 with Underflow and Inexact.
  - 0x3F400000 (0.75) → 1 with Inexact only.
  - 0x00000001 (denormal) → 0 with Underflow.
- Range edges:
  - 0x4EFFFFFF → 0x7FFFFF80, exact.
  - 0x4F000000 → 0x7FFFFFFF, Overflow.
  - 0xCF000000 → 0x80000000, no flags.
  - 0xCF000001 → 0x80000000, Overflow.
- Specials:
  - 0x7FC00000 → 0x7FFFFFFF, Exception.
  - 0xFF800000 → 0x80000000, Exception and Overflow.
  - 0x80000000 → 0, no flags.
- Back-pressure:
  - Stream of 8 back-to-back operands with out_ready toggling randomly.
  - Required: outputs in order, none dropped or duplicated, output stable while stalled, in_ready = 0 whenever out_valid & !out_ready.
- Reset mid-stream: assert rst with 2 operands in flight → out_valid = 0 next cycle, result 0, and no stale output after release.
